// File: rtl/rob_pkg.sv
// Shared types and default sizing for the reorder buffer.
// Default widths: 16 entries, 64 physical registers, 32 logical registers.
package rob_pkg;

   localparam int unsigned DEF_ROB_DEPTH = 16;
   localparam int unsigned DEF_PHY_W     = 6;
   localparam int unsigned DEF_LOG_W     = 5;
   localparam int unsigned DEF_TAG_W     = $clog2(DEF_ROB_DEPTH);

   typedef logic [DEF_TAG_W-1:0] rob_tag_t;

   typedef struct packed {
      logic                 valid;
      logic                 done;
      logic                 uses_rw;
      logic [DEF_LOG_W-1:0] log;
      logic [DEF_PHY_W-1:0] phy;
      logic [DEF_PHY_W-1:0] old_phy;
   } rob_entry_t;

endpackage

// File: rtl/rob_ptr.sv
// Wrapping pointer register used for the reorder buffer head and tail.
// Advances by one when i_inc is high and wraps from DEPTH-1 back to 0.
module rob_ptr
   import rob_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_ROB_DEPTH,
   parameter int unsigned W     = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_inc,
   output logic [W-1:0] o_ptr
);

   localparam logic [W-1:0] LP_LAST = W'(DEPTH - 1);

   logic [W-1:0] r_ptr;

   // Pointer state: increment with explicit wrap at the last entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (i_inc) begin
         r_ptr <= (r_ptr == LP_LAST) ? '0 : r_ptr + 1'b1;
      end
   end

   assign o_ptr = r_ptr;

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer between rename and commit.
// Allocates one entry per cycle at the tail, marks entries done on writeback
// (any order), and retires at most one done entry per cycle from the head.
// Optional feature macro ROB_FREE_RELEASE_EN adds the rob_free_valid /
// rob_free_phy ports and the per-entry old_phy storage that feeds them.
module reorder_buffer
   import rob_pkg::*;
#(
   parameter int unsigned ROB_DEPTH = DEF_ROB_DEPTH,
   parameter int unsigned PHY_W     = DEF_PHY_W,
   parameter int unsigned LOG_W     = DEF_LOG_W,
   parameter int unsigned TAG_W     = $clog2(ROB_DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             alloc_valid,
   output logic             alloc_ready,
   input  logic             alloc_uses_rw,
   input  logic [LOG_W-1:0] alloc_rw_log,
   input  logic [PHY_W-1:0] alloc_rw_phy,
   input  logic [PHY_W-1:0] alloc_old_phy,
   output logic [TAG_W-1:0] alloc_tag,
   input  logic             wb_valid,
   input  logic [TAG_W-1:0] wb_tag,
   output logic             retire,
   output logic             rob_commit_valid,
   output logic [PHY_W-1:0] rob_commit_reg,
   output logic [LOG_W-1:0] rob_commit_log,
   output logic [TAG_W:0]   rob_count
`ifdef ROB_FREE_RELEASE_EN
   ,
   output logic             rob_free_valid,
   output logic [PHY_W-1:0] rob_free_phy
`endif
);

   localparam logic [TAG_W:0] LP_FULL = (TAG_W + 1)'(ROB_DEPTH);

   logic [TAG_W-1:0]     w_head;
   logic [TAG_W-1:0]     w_tail;
   logic                 w_fire;
   logic                 w_retire;
   logic [TAG_W:0]       r_count;
   logic [ROB_DEPTH-1:0] r_valid;
   logic [ROB_DEPTH-1:0] r_done;
   logic [ROB_DEPTH-1:0] r_uses_rw;
   logic [LOG_W-1:0]     r_log [ROB_DEPTH];
   logic [PHY_W-1:0]     r_phy [ROB_DEPTH];
`ifdef ROB_FREE_RELEASE_EN
   logic [PHY_W-1:0]     r_old_phy [ROB_DEPTH];
`else
   logic                 w_unused_old_phy;
   assign w_unused_old_phy = ^alloc_old_phy;
`endif

   // Full is judged on count alone; no look-ahead to a same-cycle retire.
   assign alloc_ready = (r_count != LP_FULL);
   assign w_fire      = alloc_valid & alloc_ready;
   assign w_retire    = r_valid[w_head] & r_done[w_head];

   rob_ptr #(
      .DEPTH (ROB_DEPTH),
      .W     (TAG_W)
   ) u_head (
      .clk   (clk),
      .rst_n (rst_n),
      .i_inc (w_retire),
      .o_ptr (w_head)
   );

   rob_ptr #(
      .DEPTH (ROB_DEPTH),
      .W     (TAG_W)
   ) u_tail (
      .clk   (clk),
      .rst_n (rst_n),
      .i_inc (w_fire),
      .o_ptr (w_tail)
   );

   // Occupancy: unchanged when an allocate and a retire coincide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (w_fire && !w_retire) begin
         r_count <= r_count + 1'b1;
      end else if (!w_fire && w_retire) begin
         r_count <= r_count - 1'b1;
      end
   end

   // Entry state: writeback, then retire clear, then allocate (last write wins).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid   <= '0;
         r_done    <= '0;
         r_uses_rw <= '0;
         for (int i = 0; i < int'(ROB_DEPTH); i++) begin
            r_log[i] <= '0;
            r_phy[i] <= '0;
`ifdef ROB_FREE_RELEASE_EN
            r_old_phy[i] <= '0;
`endif
         end
      end else begin
         // Writebacks to empty slots are dropped; repeats just re-set done.
         if (wb_valid && r_valid[wb_tag]) begin
            r_done[wb_tag] <= 1'b1;
         end
         if (w_retire) begin
            r_valid[w_head] <= 1'b0;
            r_done[w_head]  <= 1'b0;
         end
         if (w_fire) begin
            r_valid[w_tail]   <= 1'b1;
            r_done[w_tail]    <= 1'b0;
            r_uses_rw[w_tail] <= alloc_uses_rw;
            r_log[w_tail]     <= alloc_rw_log;
            r_phy[w_tail]     <= alloc_rw_phy;
`ifdef ROB_FREE_RELEASE_EN
            r_old_phy[w_tail] <= alloc_old_phy;
`endif
         end
      end
   end

   assign alloc_tag        = w_tail;
   assign retire           = w_retire;
   assign rob_commit_valid = w_retire & r_uses_rw[w_head];
   assign rob_commit_reg   = r_phy[w_head];
   assign rob_commit_log   = r_log[w_head];
   assign rob_count        = r_count;
`ifdef ROB_FREE_RELEASE_EN
   assign rob_free_valid   = rob_commit_valid;
   assign rob_free_phy     = r_old_phy[w_head];
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with a commit scoreboard.
// Expected commits are queued at allocation and popped whenever the DUT retires.
// Build with ROB_FREE_RELEASE_EN defined to also check the free-release ports.
module tb_reorder_buffer;

   logic       clk;
   logic       rst_n;
   logic       alloc_valid;
   logic       alloc_ready;
   logic       alloc_uses_rw;
   logic [4:0] alloc_rw_log;
   logic [5:0] alloc_rw_phy;
   logic [5:0] alloc_old_phy;
   logic [3:0] alloc_tag;
   logic       wb_valid;
   logic [3:0] wb_tag;
   logic       retire;
   logic       rob_commit_valid;
   logic [5:0] rob_commit_reg;
   logic [4:0] rob_commit_log;
   logic [4:0] rob_count;
`ifdef ROB_FREE_RELEASE_EN
   logic       rob_free_valid;
   logic [5:0] rob_free_phy;
`endif

   typedef struct {
      logic       u;
      logic [4:0] l;
      logic [5:0] p;
      logic [5:0] o;
   } exp_t;

   exp_t q[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   reorder_buffer #(
      .ROB_DEPTH (16),
      .PHY_W     (6),
      .LOG_W     (5),
      .TAG_W     (4)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .alloc_valid      (alloc_valid),
      .alloc_ready      (alloc_ready),
      .alloc_uses_rw    (alloc_uses_rw),
      .alloc_rw_log     (alloc_rw_log),
      .alloc_rw_phy     (alloc_rw_phy),
      .alloc_old_phy    (alloc_old_phy),
      .alloc_tag        (alloc_tag),
      .wb_valid         (wb_valid),
      .wb_tag           (wb_tag),
      .retire           (retire),
      .rob_commit_valid (rob_commit_valid),
      .rob_commit_reg   (rob_commit_reg),
      .rob_commit_log   (rob_commit_log),
      .rob_count        (rob_count)
`ifdef ROB_FREE_RELEASE_EN
      ,
      .rob_free_valid   (rob_free_valid),
      .rob_free_phy     (rob_free_phy)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: scoreboard check at negedge, advance, then drop one-shot inputs.
   task automatic step();
      exp_t e;
      @(negedge clk);
      if (retire) begin
         if (q.size() == 0) begin
            chk("spurious_retire", {31'd0, retire}, 32'd0);
         end else begin
            e = q.pop_front();
            chk("sb_commit_valid", {31'd0, rob_commit_valid}, {31'd0, e.u});
            if (e.u) begin
               chk("sb_commit_reg", {26'd0, rob_commit_reg}, {26'd0, e.p});
               chk("sb_commit_log", {27'd0, rob_commit_log}, {27'd0, e.l});
            end
`ifdef ROB_FREE_RELEASE_EN
            chk("sb_free_valid", {31'd0, rob_free_valid}, {31'd0, e.u});
            if (e.u) chk("sb_free_phy", {26'd0, rob_free_phy}, {26'd0, e.o});
`endif
         end
      end
      @(posedge clk);
      #1;
      alloc_valid = 1'b0;
      wb_valid    = 1'b0;
   endtask

   task automatic drive_alloc(input logic [3:0] tag, input logic u, input logic [4:0] l,
                              input logic [5:0] p, input logic [5:0] o);
      exp_t e;
      chk("alloc_ready", {31'd0, alloc_ready}, 32'd1);
      chk("alloc_tag", {28'd0, alloc_tag}, {28'd0, tag});
      alloc_valid   = 1'b1;
      alloc_uses_rw = u;
      alloc_rw_log  = l;
      alloc_rw_phy  = p;
      alloc_old_phy = o;
      e.u = u; e.l = l; e.p = p; e.o = o;
      q.push_back(e);
   endtask

   task automatic drive_wb(input logic [3:0] tag);
      wb_valid = 1'b1;
      wb_tag   = tag;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      q.delete();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n         = 1'b0;
      alloc_valid   = 1'b0;
      alloc_uses_rw = 1'b0;
      alloc_rw_log  = '0;
      alloc_rw_phy  = '0;
      alloc_old_phy = '0;
      wb_valid      = 1'b0;
      wb_tag        = '0;

      // Reset values
      #12;
      chk("rst_ready", {31'd0, alloc_ready}, 32'd1);
      chk("rst_count", {27'd0, rob_count}, 32'd0);
      chk("rst_retire", {31'd0, retire}, 32'd0);
      chk("rst_commit_valid", {31'd0, rob_commit_valid}, 32'd0);
      chk("rst_commit_reg", {26'd0, rob_commit_reg}, 32'd0);
      chk("rst_commit_log", {27'd0, rob_commit_log}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Idle
      for (int i = 0; i < 3; i++) begin
         chk("idle_ready", {31'd0, alloc_ready}, 32'd1);
         chk("idle_count", {27'd0, rob_count}, 32'd0);
         chk("idle_retire", {31'd0, retire}, 32'd0);
         step();
      end

      // In-order retire
      drive_alloc(4'd0, 1'b1, 5'd1, 6'd32, 6'd1); step();
      drive_alloc(4'd1, 1'b1, 5'd2, 6'd33, 6'd2); step();
      drive_alloc(4'd2, 1'b1, 5'd3, 6'd34, 6'd3); step();
      chk("io_count3", {27'd0, rob_count}, 32'd3);
      chk("io_no_retire", {31'd0, retire}, 32'd0);
      drive_wb(4'd0);
      chk("io_wb_same_cycle", {31'd0, retire}, 32'd0);
      step();
      chk("io_commit_valid", {31'd0, rob_commit_valid}, 32'd1);
      chk("io_commit_reg", {26'd0, rob_commit_reg}, 32'd32);
      step();
      drive_wb(4'd1); step();
      drive_wb(4'd2); step();
      step();
      chk("io_drained", {27'd0, rob_count}, 32'd0);
      chk("io_sb_empty", q.size(), 32'd0);

      // Out-of-order writeback
      do_reset();
      drive_alloc(4'd0, 1'b1, 5'd4, 6'd32, 6'd4); step();
      drive_alloc(4'd1, 1'b1, 5'd5, 6'd33, 6'd5); step();
      drive_alloc(4'd2, 1'b1, 5'd6, 6'd34, 6'd6); step();
      drive_wb(4'd2); step();
      chk("ooo_hold_a", {31'd0, retire}, 32'd0);
      drive_wb(4'd1); step();
      chk("ooo_hold_b", {31'd0, retire}, 32'd0);
      step();
      chk("ooo_hold_c", {31'd0, retire}, 32'd0);
      drive_wb(4'd0); step();
      chk("ooo_r0", {26'd0, rob_commit_reg}, 32'd32);
      chk("ooo_r0_valid", {31'd0, retire}, 32'd1);
      step();
      chk("ooo_r1", {26'd0, rob_commit_reg}, 32'd33);
      chk("ooo_r1_valid", {31'd0, retire}, 32'd1);
      step();
      chk("ooo_r2", {26'd0, rob_commit_reg}, 32'd34);
      chk("ooo_r2_valid", {31'd0, retire}, 32'd1);
      step();
      chk("ooo_done", {31'd0, retire}, 32'd0);
      chk("ooo_count", {27'd0, rob_count}, 32'd0);

      // Fill, retire from full, wrap, simultaneous allocate and retire
      do_reset();
      for (int i = 0; i < 16; i++) begin
         drive_alloc(4'(i), 1'b1, 5'(i), 6'(16 + i), 6'(i));
         step();
      end
      chk("full_ready", {31'd0, alloc_ready}, 32'd0);
      chk("full_count", {27'd0, rob_count}, 32'd16);
      drive_wb(4'd0); step();
      chk("full_retire", {31'd0, retire}, 32'd1);
      chk("full_ready_hold", {31'd0, alloc_ready}, 32'd0);
      step();
      chk("full_ready_back", {31'd0, alloc_ready}, 32'd1);
      chk("full_count15", {27'd0, rob_count}, 32'd15);
      chk("full_tail_wrap", {28'd0, alloc_tag}, 32'd0);
      drive_wb(4'd1); step();
      chk("sim_retire", {31'd0, retire}, 32'd1);
      drive_alloc(4'd0, 1'b0, 5'd7, 6'd50, 6'd9); step();
      chk("sim_count", {27'd0, rob_count}, 32'd15);
      for (int i = 2; i < 16; i++) begin
         drive_wb(4'(i));
         step();
      end
      drive_wb(4'd0); step();
      chk("norw_retire", {31'd0, retire}, 32'd1);
      chk("norw_commit_valid", {31'd0, rob_commit_valid}, 32'd0);
      step();
      chk("norw_count", {27'd0, rob_count}, 32'd0);
      chk("norw_sb_empty", q.size(), 32'd0);

      // Mid-operation reset
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive_alloc(4'(i), 1'b1, 5'(10 + i), 6'(40 + i), 6'(20 + i));
         step();
      end
      drive_wb(4'd0); step();
      chk("mid_pre_count", {27'd0, rob_count}, 32'd5);
      chk("mid_pre_retire", {31'd0, retire}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_ready", {31'd0, alloc_ready}, 32'd1);
      chk("mid_count", {27'd0, rob_count}, 32'd0);
      chk("mid_retire", {31'd0, retire}, 32'd0);
      chk("mid_commit_valid", {31'd0, rob_commit_valid}, 32'd0);
      chk("mid_commit_reg", {26'd0, rob_commit_reg}, 32'd0);
      chk("mid_commit_log", {27'd0, rob_commit_log}, 32'd0);
      chk("mid_tag", {28'd0, alloc_tag}, 32'd0);
`ifdef ROB_FREE_RELEASE_EN
      chk("mid_free_valid", {31'd0, rob_free_valid}, 32'd0);
      chk("mid_free_phy", {26'd0, rob_free_phy}, 32'd0);
`endif
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      drive_alloc(4'd0, 1'b1, 5'd1, 6'd60, 6'd1); step();
      chk("post_count", {27'd0, rob_count}, 32'd1);
      step();
      chk("post_no_retire", {31'd0, retire}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
